// File: rtl/dcache_write_buffer_pkg.sv
// Shared definitions for the data-cache posted-write buffer: controller states
// and the block address/data widths used by the cache and data memory.
package dcache_write_buffer_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_GAP  = 3'd4,
        ST_RESP = 3'd5
    } wb_state_t;

endpackage

// File: rtl/dcache_write_buffer_wbuf_fifo.sv
// Circular store of posted block writes with head/tail/count bookkeeping and a
// combinational address search that reports the youngest matching entry.
module wbuf_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [ADDR_W-1:0]          i_push_addr,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    input  logic [ADDR_W-1:0]          i_search_addr,
    output logic [ADDR_W-1:0]          o_head_addr,
    output logic [DATA_W-1:0]          o_head_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_match,
    output logic [DATA_W-1:0]          o_match_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign w_do_push   = i_push & ~o_full;
    assign w_do_pop    = i_pop & ~o_empty;

    // Entry storage carries no reset: validity is defined purely by head/count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + PTR_W'(1);
            if (w_do_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so a later hit overrides an earlier one.
    always_comb begin
        o_match      = 1'b0;
        o_match_data = '0;
        w_idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == i_search_addr)) begin
                o_match      = 1'b1;
                o_match_data = r_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the data cache and data memory: absorbs write-backs
// in one cycle, drains them in the background and serves reads by forwarding.
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   C_READ,
    input  logic                   C_WRITE,
    input  logic [ADDR_W-1:0]      C_ADDRESS,
    input  logic [DATA_W-1:0]      C_WRITEDATA,
    output logic [DATA_W-1:0]      C_READDATA,
    output logic                   C_BUSYWAIT,
    output logic                   DM_READ,
    output logic                   DM_WRITE,
    output logic [ADDR_W-1:0]      DM_ADDRESS,
    output logic [DATA_W-1:0]      DM_WRITEDATA,
    input  logic [DATA_W-1:0]      DM_READDATA,
    input  logic                   DM_BUSYWAIT,
    output logic                   BUF_EMPTY,
    output logic [$clog2(DEPTH):0] BUF_COUNT,
    output wb_state_t              DBG_STATE
);
    wb_state_t         r_state;
    wb_state_t         w_next_state;
    logic              r_seen_busy;
    logic [DATA_W-1:0] r_c_readdata;
    logic              r_dm_read;
    logic              r_dm_write;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [DATA_W-1:0] r_dm_wdata;

    logic              w_full;
    logic              w_empty;
    logic              w_match;
    logic [DATA_W-1:0] w_match_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_done;
    logic              w_pop;

    // A memory access completes on the first idle-memory edge after it was seen busy.
    assign w_done = r_seen_busy & ~DM_BUSYWAIT;
    assign w_pop  = (r_state == ST_WR) & w_done;

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk         (CLK),
        .i_rst_n       (RESET),
        .i_push        (C_WRITE & ~C_READ),
        .i_push_addr   (C_ADDRESS),
        .i_push_data   (C_WRITEDATA),
        .i_pop         (w_pop),
        .i_search_addr (C_ADDRESS),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (BUF_COUNT),
        .o_match       (w_match),
        .o_match_data  (w_match_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (C_READ && w_match) w_next_state = ST_FWD;
                else if (C_READ)       w_next_state = ST_RD;
                else if (!w_empty)     w_next_state = ST_WR;
            end
            ST_FWD:  w_next_state = ST_RESP;
            ST_RD:   if (w_done) w_next_state = ST_RESP;
            ST_WR:   if (w_done) w_next_state = ST_GAP;
            ST_GAP:  w_next_state = ST_IDLE;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_seen_busy  <= 1'b0;
            r_c_readdata <= '0;
            r_dm_read    <= 1'b0;
            r_dm_write   <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
        end else begin
            if (r_state == ST_RD || r_state == ST_WR) r_seen_busy <= r_seen_busy | DM_BUSYWAIT;
            else                                      r_seen_busy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_next_state == ST_RD) begin
                        r_dm_read <= 1'b1;
                        r_dm_addr <= C_ADDRESS;
                    end else if (w_next_state == ST_WR) begin
                        r_dm_write <= 1'b1;
                        r_dm_addr  <= w_head_addr;
                        r_dm_wdata <= w_head_data;
                    end
                end
                ST_FWD: r_c_readdata <= w_match_data;
                ST_RD: begin
                    if (w_done) begin
                        r_c_readdata <= DM_READDATA;
                        r_dm_read    <= 1'b0;
                    end
                end
                ST_WR: if (w_done) r_dm_write <= 1'b0;
                default: ;
            endcase
        end
    end

    assign C_BUSYWAIT   = (C_WRITE & (w_full | C_READ)) | (C_READ & (r_state != ST_RESP));
    assign C_READDATA   = r_c_readdata;
    assign DM_READ      = r_dm_read;
    assign DM_WRITE     = r_dm_write;
    assign DM_ADDRESS   = r_dm_addr;
    assign DM_WRITEDATA = r_dm_wdata;
    assign BUF_EMPTY    = w_empty;
    assign DBG_STATE    = r_state;

endmodule
